// File: rtl/seq_det_sched_pkg.sv
// Shared types and defaults for the shared "01011" detector scheduler.
package seq_det_pkg;

  localparam int unsigned NCH_DEF = 4;
  localparam int unsigned W_DEF   = 16;

  // One-hot scheduler states
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GRANT  = 4'b0010,
    ST_SHIFT  = 4'b0100,
    ST_REPORT = 4'b1000
  } state_e;

endpackage

// File: rtl/seq_det_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after ptr_i,
// wrapping modulo NCH. Purely combinational.
module rr_arbiter
  import seq_det_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned IDW = $clog2(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [NCH-1:0] gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           valid_o
);

  int unsigned pos;

  // Scan requesters starting at the pointer; first hit wins
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pos = 32'(ptr_i) + i;
      if (pos >= NCH) pos = pos - NCH;
      if (!valid_o && req_i[IDW'(pos)]) begin
        valid_o            = 1'b1;
        gnt_o[IDW'(pos)]   = 1'b1;
        idx_o              = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Scheduler sharing one serial "01011" Mealy detector between NCH requesters.
// Arbitrates round-robin, clears the detector for one cycle, shifts the
// granted frame MSB-first into the detector and reports the hit count.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int unsigned NCH = NCH_DEF,
  parameter int unsigned W   = W_DEF,
  parameter int unsigned IDW = $clog2(NCH),
  parameter int unsigned CW  = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [NCH*W-1:0] data,
  output logic [NCH-1:0]   gnt,
  output logic             det_rst_n,
  output logic             det_x,
  input  logic             det_z,
  output logic             busy,
  output logic             done,
  output logic [IDW-1:0]   done_id,
  output logic [CW-1:0]    hit_cnt
);

  state_e           state_q;
  logic [NCH-1:0]   gnt_q;
  logic             busy_q;
  logic             done_q;
  logic [IDW-1:0]   done_id_q;
  logic [CW-1:0]    hit_cnt_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [IDW-1:0]   rr_ptr_d;
  logic [IDW-1:0]   id_q;
  logic [W-1:0]     shreg_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [CW-1:0]    bitcnt_q;
  logic [CW-1:0]    bitcnt_d;

  logic [NCH-1:0]   arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_valid;
  logic [W-1:0]     frame [NCH];

  rr_arbiter #(
    .NCH (NCH),
    .IDW (IDW)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Unpack the flat frame bus into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      frame[i] = data[i*W +: W];
    end
  end

  // Next pointer, saturating hit count and bit count
  always_comb begin
    rr_ptr_d = (arb_idx == IDW'(NCH - 1)) ? '0 : arb_idx + IDW'(1);
    cnt_d    = (det_z && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
    bitcnt_d = bitcnt_q + CW'(1);
  end

  // Scheduler FSM with registered grant/busy/done/result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      hit_cnt_q <= '0;
      rr_ptr_q  <= '0;
      id_q      <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_REPORT: begin
          if (arb_valid) begin
            state_q  <= ST_GRANT;
            gnt_q    <= arb_gnt;
            id_q     <= arb_idx;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= 1'b1;
          end else begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end
        end
        ST_GRANT: begin
          shreg_q  <= frame[id_q];
          cnt_q    <= '0;
          bitcnt_q <= '0;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg_q  <= shreg_q << 1;
          cnt_q    <= cnt_d;
          bitcnt_q <= bitcnt_d;
          if (bitcnt_q == CW'(W - 1)) begin
            // The last bit's det_z is folded in via cnt_d
            state_q   <= ST_REPORT;
            done_q    <= 1'b1;
            done_id_q <= id_q;
            hit_cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Detector is cleared during reset and throughout the GRANT cycle
  assign det_rst_n = ~reset & (state_q != ST_GRANT);
  assign det_x     = (state_q == ST_SHIFT) & shreg_q[W-1];
  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
module tb_seq_det_sched;
  localparam int NCH = 4;
  localparam int W   = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] data;
  logic [NCH-1:0]   gnt;
  logic             det_rst_n;
  logic             det_x;
  logic             det_z;
  logic             busy;
  logic             done;
  logic [1:0]       done_id;
  logic [4:0]       hit_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct { int id; int cnt; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_det_sched #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .det_rst_n(det_rst_n), .det_x(det_x), .det_z(det_z), .busy(busy),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  // Behavioural "01011" overlapping Mealy detector
  logic [2:0] dst;
  always @(posedge clk or negedge det_rst_n) begin
    if (!det_rst_n) dst <= 3'd0;
    else begin
      case (dst)
        3'd0: dst <= det_x ? 3'd0 : 3'd1;
        3'd1: dst <= det_x ? 3'd2 : 3'd1;
        3'd2: dst <= det_x ? 3'd0 : 3'd3;
        3'd3: dst <= det_x ? 3'd4 : 3'd1;
        3'd4: dst <= det_x ? 3'd0 : 3'd3;
        default: dst <= 3'd0;
      endcase
    end
  end
  assign det_z = (dst == 3'd4) && det_x;

  function automatic int count_hits(input logic [15:0] f);
    int n = 0;
    for (int i = 0; i <= 11; i++)
      if (f[15-i -: 5] == 5'b01011) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cyc,
                           output logic [15:0] xb);
    ok = 1'b0; cyc = 0; xb = '0;
    while (!ok && cyc < budget) begin
      step();
      cyc++;
      if (busy && gnt == '0 && !done) xb = {xb[14:0], det_x};
      if (done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; data = '0;
    #2;
    total++; if (gnt !== 4'b0)   begin bad++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (done_id !== 2'd0) begin bad++; $display("FAIL rst_done_id: got %0d want 0", done_id); end
    total++; if (hit_cnt !== 5'd0) begin bad++; $display("FAIL rst_hit_cnt: got %0d want 0", hit_cnt); end
    total++; if (det_x !== 1'b0) begin bad++; $display("FAIL rst_det_x: got %b want 0", det_x); end
    total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL rst_det_rst_n: got %b want 0", det_rst_n); end
    step(); step();
    reset = 1'b0;
    step();
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    total++; if (det_rst_n !== 1'b1) begin bad++; $display("FAIL rst_idle_det_rst_n: got %b want 1", det_rst_n); end
  endtask

  task automatic test_frame(input int ch, input logic [15:0] f, input int expc,
                            input string nm);
    bit ok; int cyc; logic [15:0] xb; exp_t e;
    data[ch*W +: W] = f;
    req = 4'(1 << ch);
    sb.push_back('{ch, expc});
    step();
    total++; if (gnt !== 4'(1 << ch)) begin bad++; $display("FAIL %s_gnt: got %b want %b", nm, gnt, 4'(1 << ch)); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
    total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL %s_det_clr: got %b want 0", nm, det_rst_n); end
    req = '0;
    wait_done(40, ok, cyc, xb);
    total++; if (!ok) begin bad++; $display("FAIL %s_timeout: got no done want done", nm); end
    total++; if (cyc + 1 != 18) begin bad++; $display("FAIL %s_latency: got %0d want 18", nm, cyc + 1); end
    total++; if (xb !== f) begin bad++; $display("FAIL %s_det_x: got %h want %h", nm, xb, f); end
    if (ok) begin
      if (sb.size() == 0) begin
        total++; bad++; $display("FAIL %s_sb: got done want empty queue", nm);
      end else begin
        e = sb.pop_front();
        total++; if (done_id !== 2'(e.id)) begin bad++; $display("FAIL %s_done_id: got %0d want %0d", nm, done_id, e.id); end
        total++; if (hit_cnt !== 5'(e.cnt)) begin bad++; $display("FAIL %s_hit_cnt: got %0d want %0d", nm, hit_cnt, e.cnt); end
      end
    end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got %b want 0", nm, busy); end
    total++; if (hit_cnt !== 5'(expc)) begin bad++; $display("FAIL %s_held: got %0d want %0d", nm, hit_cnt, expc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f[4];
    int order[5] = '{0, 1, 2, 3, 0};
    int ngnt = 0, ndone = 0, cyc = 0;
    bit prev_done = 1'b0;
    exp_t e;
    reset = 1'b1; step(); reset = 1'b0; step();
    for (int c = 0; c < 4; c++) begin
      f[c] = 16'($urandom);
      data[c*W +: W] = f[c];
    end
    for (int k = 0; k < 5; k++) sb.push_back('{order[k], count_hits(f[order[k]])});
    req = '1;
    while (ndone < 5 && cyc < 120) begin
      step();
      cyc++;
      if (prev_done) begin
        total++; if (gnt === 4'b0) begin bad++; $display("FAIL b2b_bubble: got %b want a grant", gnt); end
      end
      if (gnt !== 4'b0) begin
        total++;
        if (ngnt >= 5) begin bad++; $display("FAIL b2b_extra_gnt: got %b want none", gnt); end
        else if (gnt !== 4'(1 << order[ngnt])) begin bad++; $display("FAIL b2b_gnt%0d: got %b want %b", ngnt, gnt, 4'(1 << order[ngnt])); end
        ngnt++;
        if (ngnt == 5) req = '0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL b2b_sb: got done want empty queue");
        end else begin
          e = sb.pop_front();
          total++; if (done_id !== 2'(e.id)) begin bad++; $display("FAIL b2b_done_id%0d: got %0d want %0d", ndone, done_id, e.id); end
          total++; if (hit_cnt !== 5'(e.cnt)) begin bad++; $display("FAIL b2b_hit_cnt%0d: got %0d want %0d", ndone, hit_cnt, e.cnt); end
        end
        ndone++;
      end
      prev_done = done;
    end
    total++; if (ndone != 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", ndone); end
    req = '0;
    step();
  endtask

  task automatic test_reset_midframe();
    int nd = 0;
    data[0 +: W] = 16'b0101_1000_0000_0000;
    req = 4'b0001;
    step();
    req = '0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    total++; if (gnt !== 4'b0) begin bad++; $display("FAIL mid_gnt: got %b want 0000", gnt); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    total++; if (det_x !== 1'b0) begin bad++; $display("FAIL mid_det_x: got %b want 0", det_x); end
    total++; if (det_rst_n !== 1'b0) begin bad++; $display("FAIL mid_det_rst_n: got %b want 0", det_rst_n); end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) nd++;
    end
    total++; if (nd != 0) begin bad++; $display("FAIL mid_no_done: got %0d want 0", nd); end
    test_frame(0, 16'b0101_1000_0000_0000, 1, "c5_rerun");
  endtask

  task automatic test_drop();
    int seen3 = 0, id3 = 0, nd = 0;
    exp_t e;
    data[0 +: W] = 16'b0101_1000_0000_0000;
    data[3*W +: W] = 16'b0101_1010_1100_0000;
    req = 4'b0001;
    sb.push_back('{0, 1});
    step();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL drop_gnt0: got %b want 0001", gnt); end
    req = 4'b1000;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 4) req = '0;
      if (gnt[3]) seen3++;
      if (done) begin
        nd++;
        if (done_id == 2'd3) id3++;
        if (sb.size() == 0) begin
          total++; bad++; $display("FAIL drop_sb: got done want empty queue");
        end else begin
          e = sb.pop_front();
          total++; if (done_id !== 2'(e.id)) begin bad++; $display("FAIL drop_done_id: got %0d want %0d", done_id, e.id); end
          total++; if (hit_cnt !== 5'(e.cnt)) begin bad++; $display("FAIL drop_hit_cnt: got %0d want %0d", hit_cnt, e.cnt); end
        end
      end
    end
    total++; if (seen3 != 0) begin bad++; $display("FAIL drop_gnt3: got %0d want 0", seen3); end
    total++; if (id3 != 0) begin bad++; $display("FAIL drop_id3: got %0d want 0", id3); end
    total++; if (nd != 1) begin bad++; $display("FAIL drop_ndone: got %0d want 1", nd); end
  endtask

  initial begin
    test_reset();
    test_frame(0, 16'b0101_1000_0000_0000, 1, "c1");
    test_frame(2, 16'b0101_1010_1100_0000, 2, "c2");
    test_frame(1, 16'h0000, 0, "c3");
    test_back_to_back();
    test_reset_midframe();
    test_drop();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_left: got %0d want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
